// File: rtl/line_buffer.sv
// line_buffer: ping-pong scanline buffer between the shape pipeline and the
// display serialiser, single clock domain.
//   - Two banks of LINE_WIDTH pixels. One bank fills from the pixel stream
//     while the other replays to the display on pixel strobes.
//   - 'resume' tells upstream that a bank has become free for the next line.
//   - 'underflow' is a sticky flag: a line start found no complete line.
// Build option: define LINE_BUFFER_STATS_EN to add the underflow_cnt output,
// a saturating count of underflow events.
module line_buffer #(
  parameter int                  LINE_WIDTH = 1024,
  parameter int                  X_W        = 11,
  parameter int                  Y_W        = 12,
  parameter int                  COLOR_W    = 12,
  parameter logic [COLOR_W-1:0]  BG_COLOR   = 'hF0F
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_program,
  input  logic [X_W-1:0]     pix_x,
  input  logic [Y_W-1:0]     pix_y,
  input  logic [COLOR_W-1:0] pix_data,
  output logic               resume,
  input  logic               disp_line_start,
  input  logic               disp_pix_en,
  output logic [COLOR_W-1:0] disp_data,
  output logic               disp_valid,
  output logic [Y_W-1:0]     disp_line_y,
`ifdef LINE_BUFFER_STATS_EN
  output logic [15:0]        underflow_cnt,
`endif
  output logic               underflow
);

  localparam int AW    = $clog2(2 * LINE_WIDTH);
  localparam int DEPTH = 2 * LINE_WIDTH;

  // Bank life cycle: EMPTY -> FILLING -> FULL -> READING -> EMPTY.
  localparam logic [1:0] EMPTY   = 2'd0;
  localparam logic [1:0] FILLING = 2'd1;
  localparam logic [1:0] FULL    = 2'd2;
  localparam logic [1:0] READING = 2'd3;

  localparam logic [X_W-1:0] LAST_X = X_W'(LINE_WIDTH - 1);
  localparam logic [X_W:0]   LW_EXT = (X_W + 1)'(LINE_WIDTH);

  // Flat storage: bank 0 occupies [0, LINE_WIDTH), bank 1 the upper half.
  function automatic logic [AW-1:0] mem_addr(input logic bank, input logic [X_W-1:0] x);
    logic [AW-1:0] base;
    base = bank ? AW'(LINE_WIDTH) : '0;
    return base + AW'(x);
  endfunction

`ifdef LINE_BUFFER_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
`endif

  logic [COLOR_W-1:0]    mem [0:DEPTH-1];

  // Control state
  logic [1:0][1:0]       bank_st;
  logic [1:0][1:0]       bank_nxt;
  logic                  wr_bank;
  logic                  rd_bank;
  logic                  rd_bank_nxt;
  logic                  armed;
  logic                  resume_pending;
  logic [X_W-1:0]        rd_x;
  logic [1:0][Y_W-1:0]   line_y;

  // Decoded events for this cycle
  logic                  pix_in_range;
  logic                  wr_accept;
  logic                  arm_go;
  logic                  wr_en;
  logic                  line_done;
  logic                  cur_reading;
  logic                  start_go;
  logic                  abort;
  logic                  start_bank;
  logic                  start_ok;
  logic                  start_under;
  logic                  rd_go;
  logic                  rd_last;
  logic                  bg_go;
  logic                  resume_go;

  // Output stage registers
  logic [COLOR_W-1:0]    rd_q_p1;
  logic                  src_mem_p1;
  logic                  src_bg_p1;
  logic                  vld_p1;

  // Decode write-side and read-side events from the current bank state.
  always_comb begin
    pix_in_range = ({1'b0, pix_x} < LW_EXT);
    wr_accept    = !pix_program && pix_in_range;
    // A line only begins on column 0 into a free bank; anything else while
    // idle (including repeated last-column pixels during a pause) is dropped.
    arm_go       = wr_accept && !armed && (pix_x == '0) && (bank_st[wr_bank] == EMPTY);
    wr_en        = wr_accept && (armed || arm_go);
    line_done    = wr_accept && armed && (pix_x == LAST_X);

    cur_reading  = (bank_st[rd_bank] == READING);
    start_go     = !pix_program && disp_line_start;
    abort        = start_go && cur_reading;
    // After an abort the next candidate is the other bank.
    start_bank   = abort ? ~rd_bank : rd_bank;
    start_ok     = start_go && (bank_st[start_bank] == FULL);
    start_under  = start_go && !start_ok;
    // A strobe coinciding with a line start is answered with background.
    rd_go        = !pix_program && disp_pix_en && !disp_line_start && cur_reading;
    rd_last      = rd_go && (rd_x == LAST_X);
    bg_go        = !pix_program && disp_pix_en && !rd_go;

    // Registered state already reflects any bank freed in the previous
    // cycle, so a simultaneous completion and free yields one pulse.
    resume_go    = resume_pending && (bank_st[wr_bank] == EMPTY);
  end

  // Next bank state; write and read sides never touch the same bank because
  // they act on disjoint state sets.
  always_comb begin
    bank_nxt    = bank_st;
    rd_bank_nxt = rd_bank;
    if (arm_go)    bank_nxt[wr_bank] = FILLING;
    if (line_done) bank_nxt[wr_bank] = FULL;
    if (abort)     bank_nxt[rd_bank] = EMPTY;
    if (start_ok)  bank_nxt[start_bank] = READING;
    if (rd_last)   bank_nxt[rd_bank] = EMPTY;
    if (abort || rd_last) rd_bank_nxt = ~rd_bank;
  end

  // Bank ownership, arming and resume handshake; cleared by reset or program.
  always_ff @(posedge clk) begin
    if (!rst_n || pix_program) begin
      bank_st        <= {EMPTY, EMPTY};
      wr_bank        <= 1'b0;
      rd_bank        <= 1'b0;
      armed          <= 1'b0;
      resume_pending <= 1'b0;
      resume         <= 1'b0;
    end else begin
      bank_st        <= bank_nxt;
      wr_bank        <= wr_bank ^ line_done;
      rd_bank        <= rd_bank_nxt;
      if (line_done)
        armed <= 1'b0;
      else if (arm_go)
        armed <= 1'b1;
      resume         <= resume_go;
      resume_pending <= line_done | (resume_pending & ~resume_go);
    end
  end

  // Read pointer: restarts on a line start, saturates at the last column.
  always_ff @(posedge clk) begin
    if (!rst_n)
      rd_x <= '0;
    else if (start_ok)
      rd_x <= '0;
    else if (rd_go && !rd_last)
      rd_x <= rd_x + X_W'(1);
  end

  // Row bookkeeping: latch each line's y when it arms.
  always_ff @(posedge clk) begin
    if (arm_go)
      line_y[wr_bank] <= pix_y;
  end

  // Displayed row and sticky underflow; only reset clears these.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      disp_line_y <= '0;
      underflow   <= 1'b0;
    end else begin
      if (start_ok)
        disp_line_y <= line_y[start_bank];
      if (start_under)
        underflow <= 1'b1;
    end
  end

`ifdef LINE_BUFFER_STATS_EN
  // Saturating underflow event counter; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n)
      underflow_cnt <= '0;
    else if (start_under)
      underflow_cnt <= sat_inc16(underflow_cnt);
  end
`endif

  // ---- stage p0 -> p1: storage write port and registered read port ----
  // Pixel storage with synchronous read so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[mem_addr(wr_bank, pix_x)] <= pix_data;
    if (rd_go)
      rd_q_p1 <= mem[mem_addr(rd_bank, rd_x)];
  end

  // Output source select; disp_data holds between strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      src_mem_p1 <= 1'b0;
      src_bg_p1  <= 1'b0;
    end else if (rd_go) begin
      src_mem_p1 <= 1'b1;
      src_bg_p1  <= 1'b0;
    end else if (bg_go) begin
      src_mem_p1 <= 1'b0;
      src_bg_p1  <= 1'b1;
    end
  end

  // Output valid: exactly one cycle after each accepted strobe.
  always_ff @(posedge clk) begin
    if (!rst_n || pix_program)
      vld_p1 <= 1'b0;
    else
      vld_p1 <= rd_go | bg_go;
  end

  // ---- stage p1: display outputs ----
  // Pixel colour mux: replayed data, background, or the post-reset zero.
  always_comb begin
    disp_data = '0;
    if (src_mem_p1)
      disp_data = rd_q_p1;
    else if (src_bg_p1)
      disp_data = BG_COLOR;
  end

  assign disp_valid = vld_p1;

endmodule

// File: tb/tb_line_buffer.sv
// tb_line_buffer: directed bench for line_buffer (default parameters).
// A short table drives the display side with no line available; longer
// hand-written sequences fill and replay full lines and cover the program
// abort and simultaneous complete/free cases.
`timescale 1ns/1ps
module tb_line_buffer;

  localparam int LW = 1024;
  localparam int XW = 11;
  localparam int YW = 12;
  localparam int CW = 12;
  localparam logic [CW-1:0] BG = 12'hF0F;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pix_program;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic [CW-1:0] pix_data;
  logic          resume;
  logic          disp_line_start;
  logic          disp_pix_en;
  logic [CW-1:0] disp_data;
  logic          disp_valid;
  logic [YW-1:0] disp_line_y;
  logic          underflow;
`ifdef LINE_BUFFER_STATS_EN
  logic [15:0]   underflow_cnt;
`endif

  always #5 clk = ~clk;

  line_buffer #(
    .LINE_WIDTH(LW), .X_W(XW), .Y_W(YW), .COLOR_W(CW), .BG_COLOR(BG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix_program(pix_program),
    .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data), .resume(resume),
    .disp_line_start(disp_line_start), .disp_pix_en(disp_pix_en),
    .disp_data(disp_data), .disp_valid(disp_valid), .disp_line_y(disp_line_y),
`ifdef LINE_BUFFER_STATS_EN
    .underflow_cnt(underflow_cnt),
`endif
    .underflow(underflow)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int tcount = 0;
  int resume_cnt = 0;
  int last_resume_t = -1;
  int t_wdone = 0;
  int t_rdone = 0;
  int rc = 0;
  logic [CW-1:0] rx_q [$];

  typedef struct {
    logic          start;
    logic          en;
    logic          exp_valid;
    logic [CW-1:0] exp_data;
    logic          exp_uf;
    logic [15:0]   exp_cnt;
  } vec_t;
  vec_t vecs [6];

  function automatic logic [CW-1:0] col(input int x, input int off);
    return CW'(x + off);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
    tcount++;
    if (resume === 1'b1) begin
      resume_cnt++;
      last_resume_t = tcount;
    end
    if (disp_valid === 1'b1) rx_q.push_back(disp_data);
  endtask

  task automatic idle_pix();
    pix_x    = XW'(LW - 1);
    pix_data = 12'hABC;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Stream one full line; optionally slip in an out-of-range column mid-line.
  task automatic write_line(input int y, input int off, input bit inject);
    pix_y = YW'(y);
    for (int x = 0; x < LW; x++) begin
      if (inject && x == 512) begin
        pix_x    = 11'd1030;
        pix_data = 12'h111;
        tick();
      end
      pix_x    = XW'(x);
      pix_data = col(x, off);
      tick();
    end
    t_wdone = tcount;
    idle_pix();
  endtask

  task automatic start_line();
    disp_line_start = 1'b1;
    tick();
    disp_line_start = 1'b0;
  endtask

  // n strobes, optionally writing a line in lockstep; captures returned pixels.
  task automatic strobes(input int n, input bit wr, input int y, input int off);
    rx_q.delete();
    pix_y = YW'(y);
    for (int i = 0; i < n; i++) begin
      disp_pix_en = 1'b1;
      if (wr) begin
        pix_x    = XW'(i);
        pix_data = col(i, off);
      end
      tick();
    end
    t_rdone = tcount;
    if (wr) t_wdone = tcount;
    disp_pix_en = 1'b0;
    idle_pix();
    tick();
  endtask

  task automatic check_data(input string name, input int off, input int n);
    int bad;
    bad = -1;
    n_cmp++;
    if (rx_q.size() != n) begin
      n_fail++;
      $display("FAIL %s: got %0d pixels, expected %0d", name, rx_q.size(), n);
    end else begin
      for (int i = 0; i < n; i++)
        if (bad < 0 && rx_q[i] !== col(i, off)) bad = i;
      if (bad >= 0) begin
        n_fail++;
        $display("FAIL %s: pixel %0d got 0x%0h, expected 0x%0h", name, bad, rx_q[bad], col(bad, off));
      end
    end
  endtask

  task automatic check_bg(input string name, input int n);
    int bad;
    bad = -1;
    n_cmp++;
    if (rx_q.size() != n) begin
      n_fail++;
      $display("FAIL %s: got %0d pixels, expected %0d", name, rx_q.size(), n);
    end else begin
      for (int i = 0; i < n; i++)
        if (bad < 0 && rx_q[i] !== BG) bad = i;
      if (bad >= 0) begin
        n_fail++;
        $display("FAIL %s: pixel %0d got 0x%0h, expected 0x%0h", name, bad, rx_q[bad], BG);
      end
    end
  endtask

  initial begin
    vecs[0] = '{start: 1'b1, en: 1'b0, exp_valid: 1'b0, exp_data: 12'h000, exp_uf: 1'b1, exp_cnt: 16'd1};
    vecs[1] = '{start: 1'b0, en: 1'b1, exp_valid: 1'b1, exp_data: BG,      exp_uf: 1'b1, exp_cnt: 16'd1};
    vecs[2] = '{start: 1'b0, en: 1'b1, exp_valid: 1'b1, exp_data: BG,      exp_uf: 1'b1, exp_cnt: 16'd1};
    vecs[3] = '{start: 1'b0, en: 1'b0, exp_valid: 1'b0, exp_data: BG,      exp_uf: 1'b1, exp_cnt: 16'd1};
    vecs[4] = '{start: 1'b1, en: 1'b0, exp_valid: 1'b0, exp_data: BG,      exp_uf: 1'b1, exp_cnt: 16'd2};
    vecs[5] = '{start: 1'b0, en: 1'b1, exp_valid: 1'b1, exp_data: BG,      exp_uf: 1'b1, exp_cnt: 16'd2};

    rst_n = 1'b0;
    pix_program = 1'b0;
    pix_y = '0;
    disp_line_start = 1'b0;
    disp_pix_en = 1'b0;
    idle_pix();
    idle(3);

    // Reset state
    check("rst_resume", resume, 0);
    check("rst_valid", disp_valid, 0);
    check("rst_data", disp_data, 0);
    check("rst_line_y", disp_line_y, 0);
    check("rst_underflow", underflow, 0);
`ifdef LINE_BUFFER_STATS_EN
    check("rst_cnt", underflow_cnt, 0);
`endif
    rst_n = 1'b1;
    resume_cnt = 0;

    // Line starts with both banks empty
    for (int i = 0; i < 6; i++) begin
      disp_line_start = vecs[i].start;
      disp_pix_en     = vecs[i].en;
      tick();
      check($sformatf("tbl%0d_valid", i), disp_valid, vecs[i].exp_valid);
      check($sformatf("tbl%0d_data", i), disp_data, vecs[i].exp_data);
      check($sformatf("tbl%0d_underflow", i), underflow, vecs[i].exp_uf);
      check($sformatf("tbl%0d_line_y", i), disp_line_y, 0);
`ifdef LINE_BUFFER_STATS_EN
      check($sformatf("tbl%0d_cnt", i), underflow_cnt, vecs[i].exp_cnt);
`endif
    end
    disp_line_start = 1'b0;
    disp_pix_en = 1'b0;
    tick();

    // First line into bank 0, resume one cycle after it is full
    rc = resume_cnt;
    write_line(0, 0, 1'b0);
    idle(2);
    check("l0_resume_cnt", resume_cnt - rc, 1);
    check("l0_resume_time", last_resume_t, t_wdone + 1);
    start_line();
    check("l0_line_y", disp_line_y, 0);
    strobes(LW, 1'b0, 0, 0);
    check_data("l0_data", 0, LW);
    check("l0_valid_drop", disp_valid, 0);
    check("l0_no_resume_on_read", resume_cnt - rc, 1);

    // Line A into bank 1 (bank 0 free: resume), then a 50-cycle pause on x=1023
    rc = resume_cnt;
    write_line(1, 100, 1'b0);
    idle(50);
    check("la_resume_cnt", resume_cnt - rc, 1);
    check("la_resume_time", last_resume_t, t_wdone + 1);
    // Line B into bank 0 while bank 1 unread: no resume
    write_line(2, 300, 1'b1);
    idle(50);
    check("lb_no_resume", resume_cnt - rc, 1);
    start_line();
    check("la_line_y", disp_line_y, 1);
    strobes(LW, 1'b0, 0, 0);
    check_data("la_data", 100, LW);
    check("la_read_resume_cnt", resume_cnt - rc, 2);
    check("la_read_resume_time", last_resume_t, t_rdone + 1);
    start_line();
    check("lb_line_y", disp_line_y, 2);
    strobes(LW, 1'b0, 0, 0);
    check_data("lb_data", 300, LW);
    check("lb_read_no_resume", resume_cnt - rc, 2);

    // Program pulse mid-replay at rd_x=500
    rc = resume_cnt;
    write_line(3, 500, 1'b0);
    idle(2);
    check("lc_resume_cnt", resume_cnt - rc, 1);
    start_line();
    check("lc_line_y", disp_line_y, 3);
    strobes(500, 1'b0, 0, 0);
    check_data("lc_partial", 500, 500);
    pix_program = 1'b1;
    disp_pix_en = 1'b1;
    tick();
    pix_program = 1'b0;
    disp_pix_en = 1'b0;
    check("prog_valid", disp_valid, 0);
    check("prog_resume", resume, 0);
    check("prog_underflow_kept", underflow, 1);
    check("prog_line_y_kept", disp_line_y, 3);
    rc = resume_cnt;
    strobes(3, 1'b0, 0, 0);
    check_bg("prog_bg", 3);
    idle(20);
    check("prog_no_resume", resume_cnt - rc, 0);
    start_line();
    check("prog_banks_empty", underflow, 1);
`ifdef LINE_BUFFER_STATS_EN
    check("prog_cnt", underflow_cnt, 3);
`endif
    strobes(2, 1'b0, 0, 0);
    check_bg("prog_bg2", 2);
    write_line(4, 700, 1'b0);
    idle(2);
    check("ld_resume_cnt", resume_cnt - rc, 1);
    check("ld_resume_time", last_resume_t, t_wdone + 1);

    // Completion of one bank coinciding with the last read of the other
    rc = resume_cnt;
    write_line(5, 900, 1'b0);
    idle(5);
    check("le_no_resume", resume_cnt - rc, 0);
    start_line();
    check("ld_line_y", disp_line_y, 4);
    strobes(LW, 1'b0, 0, 0);
    check_data("ld_data", 700, LW);
    check("ld_read_resume_cnt", resume_cnt - rc, 1);
    rc = resume_cnt;
    start_line();
    check("le_line_y", disp_line_y, 5);
    strobes(LW, 1'b1, 6, 1100);
    idle(10);
    check_data("le_data", 900, LW);
    check("sim_same_cycle", t_wdone, t_rdone);
    check("sim_resume_cnt", resume_cnt - rc, 1);
    check("sim_resume_time", last_resume_t, t_rdone + 1);
    start_line();
    check("lf_line_y", disp_line_y, 6);
    strobes(LW, 1'b0, 0, 0);
    check_data("lf_data", 1100, LW);

    // Only reset clears the sticky flag and output registers
    rst_n = 1'b0;
    idle(2);
    check("rst2_underflow", underflow, 0);
    check("rst2_data", disp_data, 0);
    check("rst2_line_y", disp_line_y, 0);
    check("rst2_valid", disp_valid, 0);
`ifdef LINE_BUFFER_STATS_EN
    check("rst2_cnt", underflow_cnt, 0);
`endif
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
